// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writers after the D stage as
// {valid, destination, Tnew} entries, derives the D-stage stall and forwarding
// selects from them, and owns the multiply/divide busy counter.
module hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int TW       = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    D_rs,
    input  logic [4:0]    D_rt,
    input  logic [TW-1:0] D_Tuse_rs,
    input  logic [TW-1:0] D_Tuse_rt,
    input  logic [4:0]    D_dst,
    input  logic          D_RegWrite,
    input  logic [TW-1:0] D_Tnew,
    input  logic          D_HILO,
    input  logic          D_Start,
    input  logic          D_MDdiv,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
    output logic          md_busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    // Entry k describes the writer that left D k cycles ago.
    logic          vld  [1:DEPTH];
    logic [4:0]    dst  [1:DEPTH];
    logic [TW-1:0] tnew [1:DEPTH];
    logic [CW-1:0] cnt;

    logic          hit_rs, hit_rt;
    logic [SW-1:0] k_rs, k_rt;
    logic [TW-1:0] tn_rs, tn_rt;
    logic          stall_rs, stall_rt, stall_md;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    // Find the youngest matching entry per source; the loop runs oldest to
    // youngest so the youngest match overwrites any older one (WAW shadowing).
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        k_rs   = '0;
        k_rt   = '0;
        tn_rs  = '0;
        tn_rt  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (vld[k] && (dst[k] == D_rs) && (D_rs != 5'd0)) begin
                hit_rs = 1'b1;
                k_rs   = SW'(k);
                tn_rs  = tnew[k];
            end
            if (vld[k] && (dst[k] == D_rt) && (D_rt != 5'd0)) begin
                hit_rt = 1'b1;
                k_rt   = SW'(k);
                tn_rt  = tnew[k];
            end
        end
    end

    // Stall when the governing writer's result is later than the source's use;
    // forward only when the governing writer already has its result.
    always_comb begin
        stall_rs   = hit_rs && (tn_rs > D_Tuse_rs);
        stall_rt   = hit_rt && (tn_rt > D_Tuse_rt);
        md_busy    = (cnt != '0);
        stall_md   = D_HILO && md_busy;
        stall      = stall_rs | stall_rt | stall_md;
        fwd_rs_sel = (hit_rs && (tn_rs == '0)) ? k_rs : '0;
        fwd_rt_sel = (hit_rt && (tn_rt == '0)) ? k_rt : '0;
    end

    // Entry 1 takes the D instruction, or a bubble when D is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld[1]  <= 1'b0;
            dst[1]  <= '0;
            tnew[1] <= '0;
        end else if (flush) begin
            vld[1]  <= 1'b0;
        end else begin
            vld[1]  <= !stall && D_RegWrite && (D_dst != 5'd0);
            dst[1]  <= D_dst;
            tnew[1] <= dec_sat(D_Tnew);
        end
    end

    // Older entries shift down one stage per clock, aging Tnew toward zero.
    generate
        for (genvar gi = 2; gi <= DEPTH; gi++) begin : g_stage
            // Stage gi follows stage gi-1.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld[gi]  <= 1'b0;
                    dst[gi]  <= '0;
                    tnew[gi] <= '0;
                end else if (flush) begin
                    vld[gi]  <= 1'b0;
                end else begin
                    vld[gi]  <= vld[gi-1];
                    dst[gi]  <= dst[gi-1];
                    tnew[gi] <= dec_sat(tnew[gi-1]);
                end
            end
        end
    endgenerate

    // Multiply/divide busy counter: loaded when a start leaves D, counts down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (D_Start && !stall) begin
            cnt <= D_MDdiv ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic, each cycle compared against a history-based reference model.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_dst;
    logic [2:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_RegWrite, D_HILO, D_Start, D_MDdiv, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_dst      (D_dst),
        .D_RegWrite (D_RegWrite),
        .D_Tnew     (D_Tnew),
        .D_HILO     (D_HILO),
        .D_Start    (D_Start),
        .D_MDdiv    (D_MDdiv),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: h_*[a] is the instruction that left D a cycles ago,
    // with its Tnew as seen at D; busy while cyc < busy_until.
    bit h_v  [1:DEPTH];
    int h_dst[1:DEPTH];
    int h_tn [1:DEPTH];
    int cyc = 0;
    int busy_until = 0;

    int last_stall, last_rs, last_rt, last_busy;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int a = 1; a <= DEPTH; a++) begin
            h_v[a] = 1'b0; h_dst[a] = 0; h_tn[a] = 0;
        end
        busy_until = 0;
    endtask

    function automatic void lookup(input int s, input int tuse, output bit st, output int sel);
        st = 1'b0;
        sel = 0;
        if (s != 0) begin
            for (int a = 1; a <= DEPTH; a++) begin
                if (h_v[a] && h_dst[a] == s) begin
                    int tn;
                    tn = h_tn[a] - a;
                    if (tn < 0) tn = 0;
                    st = (tn > tuse);
                    sel = (tn == 0) ? a : 0;
                    break;
                end
            end
        end
    endfunction

    task automatic drive(input int rs, input int rt, input int tu_rs, input int tu_rt,
                         input int dst, input int rw, input int tn, input int hilo,
                         input int start, input int dv, input int fl);
        D_rs = 5'(rs); D_rt = 5'(rt);
        D_Tuse_rs = 3'(tu_rs); D_Tuse_rt = 3'(tu_rt);
        D_dst = 5'(dst); D_RegWrite = rw[0]; D_Tnew = 3'(tn);
        D_HILO = hilo[0]; D_Start = start[0]; D_MDdiv = dv[0]; flush = fl[0];
    endtask

    task automatic nop();
        drive(0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: compare outputs with the model, then advance the model.
    task automatic step();
        bit s_rs, s_rt, m_busy, m_stall;
        int sel_rs, sel_rt;
        #1;
        lookup(int'(D_rs), int'(D_Tuse_rs), s_rs, sel_rs);
        lookup(int'(D_rt), int'(D_Tuse_rt), s_rt, sel_rt);
        m_busy  = (cyc < busy_until);
        m_stall = s_rs | s_rt | (D_HILO & m_busy);
        check_val("stall", int'(stall), int'(m_stall));
        check_val("fwd_rs_sel", int'(fwd_rs_sel), sel_rs);
        check_val("fwd_rt_sel", int'(fwd_rt_sel), sel_rt);
        check_val("md_busy", int'(md_busy), int'(m_busy));
        $display("cyc %0d rs=%0d rt=%0d dst=%0d tnew=%0d hilo=%0d start=%0d flush=%0d -> stall=%0d rs_sel=%0d rt_sel=%0d busy=%0d",
                 cyc, D_rs, D_rt, D_dst, D_Tnew, D_HILO, D_Start, flush, stall, fwd_rs_sel, fwd_rt_sel, md_busy);
        last_stall = int'(stall); last_rs = int'(fwd_rs_sel);
        last_rt = int'(fwd_rt_sel); last_busy = int'(md_busy);
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else begin
            for (int a = DEPTH; a >= 2; a--) begin
                h_v[a] = h_v[a-1]; h_dst[a] = h_dst[a-1]; h_tn[a] = h_tn[a-1];
            end
            h_v[1]   = !m_stall && D_RegWrite && (D_dst != 5'd0);
            h_dst[1] = int'(D_dst);
            h_tn[1]  = int'(D_Tnew);
            if (D_Start && !m_stall) busy_until = cyc + 1 + (D_MDdiv ? 10 : 5);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        nop();
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold the current D instruction until it leaves D (bounded), counting stalls.
    task automatic run_until_free(input int max_cyc, input string tag, input bit chk_busy, output int nst);
        bit freed;
        nst = 0;
        freed = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (last_stall == 0) begin
                freed = 1'b1;
                break;
            end
            nst++;
            if (chk_busy) check_val({tag, "_busy"}, last_busy, 1);
        end
        check_val({tag, "_released"}, int'(freed), 1);
    endtask

    int nst;

    initial begin
        // Reset state, with a HI/LO reader present.
        reset = 1'b0;
        nop();
        D_HILO = 1'b1;
        D_rs = 5'd8;
        D_Tuse_rs = 3'd0;
        model_clear();
        #3;
        check_val("rst_stall", int'(stall), 0);
        check_val("rst_busy", int'(md_busy), 0);
        check_val("rst_fwd_rs", int'(fwd_rs_sel), 0);
        check_val("rst_fwd_rt", int'(fwd_rt_sel), 0);
        @(negedge clk);
        reset = 1'b1;
        nop();

        // Load then ALU use: one stall, no forwarding.
        drive(0, 0, 7, 7, 8, 1, 3, 0, 0, 0, 0); step();
        drive(0, 8, 7, 1, 10, 1, 2, 0, 0, 0, 0);
        run_until_free(5, "lw_alu", 1'b0, nst);
        check_val("lw_alu_stalls", nst, 1);
        check_val("lw_alu_fwd_rt", last_rt, 0);
        idle(3);

        // ALU then branch: one stall, then forward from stage 2.
        drive(0, 0, 7, 7, 9, 1, 2, 0, 0, 0, 0); step();
        drive(9, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        run_until_free(5, "alu_br", 1'b0, nst);
        check_val("alu_br_stalls", nst, 1);
        check_val("alu_br_fwd_rs", last_rs, 2);
        idle(3);

        // Multiply then HI read: 5 stalls; divide: 10 stalls.
        drive(0, 0, 7, 7, 0, 0, 0, 1, 1, 0, 0); step();
        check_val("mult_start_stall", last_stall, 0);
        drive(0, 0, 7, 7, 10, 1, 2, 1, 0, 0, 0);
        run_until_free(20, "mult", 1'b1, nst);
        check_val("mult_stalls", nst, 5);
        drive(0, 0, 7, 7, 0, 0, 0, 1, 1, 1, 0); step();
        drive(0, 0, 7, 7, 10, 1, 2, 1, 0, 0, 0);
        run_until_free(20, "div", 1'b1, nst);
        check_val("div_stalls", nst, 10);
        idle(3);

        // Register 0 never matches.
        drive(0, 0, 7, 7, 0, 1, 3, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check_val("r0_stall", last_stall, 0);
        check_val("r0_fwd_rs", last_rs, 0);

        // Shadowing: addu to r8 hides the older lw to r8.
        drive(0, 0, 7, 7, 8, 1, 3, 0, 0, 0, 0); step();
        drive(0, 0, 7, 7, 8, 1, 2, 0, 0, 0, 0); step();
        drive(8, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0); step();
        check_val("shadow_stall1", last_stall, 0);
        check_val("shadow_fwd1", last_rs, 0);
        step();
        check_val("shadow_stall2", last_stall, 0);
        check_val("shadow_fwd2", last_rs, 2);
        idle(3);

        // Flush during a pending load.
        drive(0, 0, 7, 7, 8, 1, 3, 0, 0, 0, 0); step();
        drive(0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 1); step();
        drive(8, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0); step();
        check_val("flush_lw_stall", last_stall, 0);
        check_val("flush_lw_fwd", last_rs, 0);

        // Flush while the multiplier is busy.
        drive(0, 0, 7, 7, 0, 0, 0, 1, 1, 0, 0); step();
        drive(0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 1); step();
        check_val("flush_md_busy_before", last_busy, 1);
        nop(); step();
        check_val("flush_md_busy_after", last_busy, 0);
        idle(2);

        // Asynchronous reset while a divide has cnt = 7.
        drive(0, 0, 7, 7, 0, 0, 0, 1, 1, 1, 0); step();
        idle(3);
        drive(0, 0, 7, 7, 0, 0, 0, 1, 0, 0, 0);
        #1;
        check_val("div7_busy", int'(md_busy), 1);
        check_val("div7_stall", int'(stall), 1);
        #1 reset = 1'b0;
        #1;
        check_val("arst_busy", int'(md_busy), 0);
        check_val("arst_stall", int'(stall), 0);
        check_val("arst_fwd_rs", int'(fwd_rs_sel), 0);
        check_val("arst_fwd_rt", int'(fwd_rt_sel), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        nop();

        // Random traffic over a small register set.
        for (int i = 0; i < 400; i++) begin
            int st, hl;
            st = ($urandom_range(0, 7) == 0) ? 1 : 0;
            hl = (st != 0 || $urandom_range(0, 3) == 0) ? 1 : 0;
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 4),
                  hl, st, $urandom_range(0, 1),
                  ($urandom_range(0, 15) == 0) ? 1 : 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the multi-stage MIPS pipeline. It tracks every in-flight register writer after the D stage as a scoreboard entry of {valid, destination, Tnew}, and compares the D-stage instruction's Tuse values against those entries. From that comparison it produces the D-stage stall and the D-stage forwarding selects. It also owns the multiply/divide busy counter that stalls HI/LO consumers.

## Interface
Parameters:
- DEPTH, default 3: number of tracked stages after D. Stage 1 = E, 2 = M, 3 = W.
- TW, default 3: width of Tnew/Tuse fields.
- MULT_LAT, default 5: busy cycles loaded for mult/multu.
- DIV_LAT, default 10: busy cycles loaded for div/divu.
- SW, default $clog2(DEPTH+1): forwarding select width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- D_rs, D_rt  in  5  source registers of the D instruction.
- D_Tuse_rs, D_Tuse_rt  in  TW  Tuse of each source. A value larger than any Tnew never stalls.
- D_dst  in  5  destination register of the D instruction.
- D_RegWrite  in  1  the D instruction writes D_dst.
- D_Tnew  in  TW  Tnew of the D instruction, measured at D.
- D_HILO  in  1  the D instruction reads or writes HI/LO.
- D_Start  in  1  the D instruction is mult/multu/div/divu.
- D_MDdiv  in  1  qualifies D_Start: 1 = div/divu, 0 = mult/multu.
- flush  in  1  exception/eret flush of all stages after D.
- stall  out  1  freeze PC and the F/D register, and insert a bubble into E.
- fwd_rs_sel, fwd_rt_sel  out  SW  0 = register file; k = forward from stage k.
- md_busy  out  1  multiply/divide unit occupied.

## Operation
- Entry k (1..DEPTH) holds vld_k, dst_k and tnew_k.
- Matching:
  - An entry matches source s when vld_k is set and dst_k == s.
  - The youngest matching entry (smallest k) governs. Older matching entries are ignored.
- Stall:
  - stall_s = the governing entry exists and tnew_k > D_Tuse_s.
  - stall_md = D_HILO && cnt != 0.
  - stall = stall_rs | stall_rt | stall_md.
- Forwarding:
  - fwd_s_sel = k when the governing entry has tnew_k == 0.
  - Otherwise fwd_s_sel = 0. Either no match exists, or the consumer stage picks the value up later.
  - Source register 0 never matches. Entries are never made valid with dst 0.
- Shift on each clock, unless reset or flush applies:
  - Entry k+1 ← entry k, with tnew decremented and saturating at 0.
  - Entry DEPTH is discarded.
  - Entry 1 ← bubble (vld 0) when stall = 1.
  - Otherwise entry 1 ← {D_RegWrite && D_dst != 0, D_dst, sat0(D_Tnew − 1)}.
- Flush:
  - On a clock edge with flush = 1, all vld ← 0 and cnt ← 0.
  - Flush has priority over the shift and the counter load.
- Multiply/divide counter cnt (width sized for max(MULT_LAT, DIV_LAT)):
  - If D_Start, stall = 0 and flush = 0: cnt ← D_MDdiv ? DIV_LAT : MULT_LAT.
  - Else if cnt != 0: cnt ← cnt − 1.
  - md_busy = (cnt != 0).
  - A new start while busy is not blocked here. The D_HILO stall already covers it, because a start instruction asserts D_HILO.

## Timing
- stall, fwd_rs_sel, fwd_rt_sel and md_busy are combinational from the current state and the D inputs. There are no registered outputs.
- Reset values, taking effect immediately and asynchronously:
  - All vld = 0 and cnt = 0.
  - Therefore stall = D_HILO && 0 = 0, fwd selects = 0, md_busy = 0.
- Reset in the middle of a multiply/divide clears cnt at once. A reset release mid-cycle takes effect at the next rising edge.
- Write-after-write handling: a younger writer to the same register shadows an older one in the same cycle it enters entry 1.
- Latency:
  - Load then ALU use (D_Tnew 3, Tuse 1): 1 stall cycle.
  - Load then branch (Tuse 0): 2 stall cycles.
  - ALU then branch (D_Tnew 2, Tuse 0): 1 stall cycle.
- Simultaneous flush and stall: the flush wins. The next cycle starts with an empty scoreboard.

## Test plan
- Load then ALU use:
  - Stimulus: lw (D_dst 8, D_Tnew 3, RegWrite) in D; next cycle add with D_rt 8, Tuse_rt 1.
  - Required: stall 1 for exactly 1 cycle; fwd_rt_sel 0 in both cycles.
- ALU then branch:
  - Stimulus: addu (dst 9, D_Tnew 2); next cycle beq with rs 9, Tuse 0.
  - Required: stall 1 for 1 cycle; the following cycle stall 0, fwd_rs_sel 2.
- Multiply then HI read:
  - Stimulus: mult (D_Start 1, D_MDdiv 0, D_HILO 1); next cycle mfhi (D_HILO 1).
  - Required: md_busy 1 and stall 1 for 5 cycles; stall 0 on the 6th cycle.
  - Repeat with div: 10 stall cycles.
- Register 0 and shadowing:
  - Stimulus: writer with dst 0 followed by a reader of rs 0, Tuse 0.
  - Required: stall 0, sel 0.
  - Stimulus: lw dst 8 followed by addu dst 8 (D_Tnew 2); then a reader of 8 with Tuse 1.
  - Required: no stall, fwd sel from the addu entry (2) once its tnew reaches 0.
- Flush during a pending load:
  - Stimulus: lw dst 8 in E (tnew 2) with flush 1; next cycle a reader of 8 with Tuse 0.
  - Required: stall 0, sel 0.
  - Stimulus: flush during md_busy.
  - Required: md_busy 0 the next cycle.
- Reset during divide:
  - Stimulus: reset driven low with cnt = 7, asynchronously.
  - Required: md_busy 0 and stall 0 before the next clock edge; all selects 0.
